// File: rtl/mdu_iter.sv
// mdu_iter: iterative RISC-V M-extension multiply/divide unit with valid/ready request and response.
// Multiplies retire MULBITS bits/cycle by shift-add; divides retire DIVBITS quotient bits/cycle by restoring steps.
module mdu_iter #(
    parameter int XLEN    = 64,
    parameter int MULBITS = 2,
    parameter int DIVBITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_funct3,
    input  logic            i_w64,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    state_t            r_state;
    logic [2:0]        r_funct3;
    logic              r_w64, r_neg, r_neg_rem, r_resp_valid;
    logic [XLEN-1:0]   r_a, r_b, r_y, r_result;
    logic [2*XLEN-1:0] r_acc, r_x;
    logic [CW-1:0]     r_cnt;
    logic              w_div, w_w32, w_sa, w_sb, w_neg_a, w_neg_b, w_b_zero, w_ovf;
    logic [XLEN-1:0]   w_a, w_b, w_mag_a, w_mag_b, w_min, w_q, w_rem, w_quo, w_rmd;
    logic [XLEN-1:0]   w_special, w_raw, w_out, w_fin;
    logic [XLEN:0]     w_sh, w_trial;
    logic [2*XLEN-1:0] w_prod, w_p;
    logic [CW-1:0]     w_n1;
    assign w_div    = r_funct3[2];
    assign w_w32    = (XLEN == 64) && r_w64;
    assign w_sa     = (r_funct3 == 3'b001) || (r_funct3 == 3'b010) || (w_div && !r_funct3[0]);
    assign w_sb     = (r_funct3 == 3'b001) || (w_div && !r_funct3[0]);
    assign w_a      = !w_w32 ? r_a : w_sa ? XLEN'($signed(r_a[31:0])) : XLEN'(r_a[31:0]);
    assign w_b      = !w_w32 ? r_b : w_sb ? XLEN'($signed(r_b[31:0])) : XLEN'(r_b[31:0]);
    assign w_neg_a  = w_sa && w_a[XLEN-1];
    assign w_neg_b  = w_sb && w_b[XLEN-1];
    assign w_mag_a  = w_neg_a ? -w_a : w_a;
    assign w_mag_b  = w_neg_b ? -w_b : w_b;
    assign w_min    = w_w32 ? ~XLEN'(32'h7FFF_FFFF) : {1'b1, {(XLEN-1){1'b0}}};
    assign w_b_zero = w_b == '0;
    assign w_ovf    = w_div && !r_funct3[0] && (w_a == w_min) && (&w_b);
    assign w_n1     = CW'((w_w32 ? 32 : XLEN) / (w_div ? DIVBITS : MULBITS) - 1);
    // Multiplicand in r_x shifts left while the multiplier in r_y shifts right; works for either word width.
    assign w_prod   = r_x * (2*XLEN)'(r_y[MULBITS-1:0]);
    always_comb begin
        w_q     = r_y;
        w_rem   = r_acc[XLEN-1:0];
        w_sh    = '0;
        w_trial = '0;
        for (int i = 0; i < DIVBITS; i++) begin
            w_sh    = {w_rem, w_q[XLEN-1]};
            w_trial = w_sh - {1'b0, r_x[XLEN-1:0]};
            w_q     = {w_q[XLEN-2:0], ~w_trial[XLEN]};
            w_rem   = w_trial[XLEN] ? w_sh[XLEN-1:0] : w_trial[XLEN-1:0];
        end
    end
    assign w_p       = r_neg ? -r_acc : r_acc;
    assign w_quo     = r_neg ? -r_y : r_y;
    assign w_rmd     = r_neg_rem ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_raw     = w_div ? (r_funct3[1] ? w_rmd : w_quo)
                     : r_funct3 == 3'b000 ? w_p[XLEN-1:0]
                     : w_w32 ? XLEN'(w_p[63:32]) : w_p[2*XLEN-1:XLEN];
    assign w_special = w_b_zero ? (r_funct3[1] ? w_a : '1) : (r_funct3[1] ? '0 : w_a);
    assign w_out     = r_state == PREP ? w_special : w_raw;
    assign w_fin     = w_w32 ? XLEN'($signed(w_out[31:0])) : w_out;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_funct3     <= '0;
            r_w64        <= 1'b0;
            r_neg        <= 1'b0;
            r_neg_rem    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_y          <= '0;
            r_result     <= '0;
            r_acc        <= '0;
            r_x          <= '0;
            r_cnt        <= '0;
        end else if (i_flush) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_req_valid) begin
                    r_funct3 <= i_funct3;
                    r_w64    <= i_w64;
                    r_a      <= i_src_a;
                    r_b      <= i_src_b;
                    r_state  <= PREP;
                end
                PREP: begin
                    r_neg     <= w_neg_a ^ w_neg_b;
                    r_neg_rem <= w_neg_a;
                    r_acc     <= '0;
                    if (w_div && (w_b_zero || w_ovf)) begin
                        r_result     <= w_fin;
                        r_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        // Dividend is left-aligned so W-type ops retire from bit 31 like full-width ones.
                        r_x     <= (2*XLEN)'(w_div ? w_mag_b : w_mag_a);
                        r_y     <= w_div ? (w_w32 ? w_mag_a << (XLEN-32) : w_mag_a) : w_mag_b;
                        r_cnt   <= w_n1;
                        r_state <= ITER;
                    end
                end
                ITER: begin
                    if (w_div) begin
                        r_y   <= w_q;
                        r_acc <= (2*XLEN)'(w_rem);
                    end else begin
                        r_acc <= r_acc + w_prod;
                        r_x   <= r_x << MULBITS;
                        r_y   <= r_y >> MULBITS;
                    end
                    if (r_cnt == '0) r_state <= FIX;
                    else r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    r_result     <= w_fin;
                    r_resp_valid <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: if (i_resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_busy       = r_state != IDLE;
    assign o_req_ready  = r_state == IDLE;
    assign o_resp_valid = r_resp_valid;
    assign o_result     = r_result;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors for mdu_iter (XLEN=64, MULBITS=2, DIVBITS=1) checked against a
// 128-bit arithmetic reference model every cycle, with literal values pinning the model.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [2:0]  i_funct3 = '0;
    logic        i_w64 = 1'b0;
    logic [63:0] i_src_a = '0;
    logic [63:0] i_src_b = '0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b1;
    logic [63:0] o_result;
    logic        o_busy;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    mdu_iter #(.XLEN(64), .MULBITS(2), .DIVBITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready), .i_funct3(i_funct3), .i_w64(i_w64), .i_src_a(i_src_a),
        .i_src_b(i_src_b), .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_result(o_result), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] ext(input logic [63:0] v, input logic w, input logic s);
        logic [63:0] x;
        x = w ? (s ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]}) : v;
        return s ? {{64{x[63]}}, x} : {64'b0, x};
    endfunction

    function automatic logic [63:0] model_res(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
        logic sa, sb;
        logic signed [127:0] xa, xb, p;
        logic [127:0] r;
        sa = f inside {3'd1, 3'd2, 3'd4, 3'd6};
        sb = f inside {3'd1, 3'd4, 3'd6};
        xa = ext(a, w, sa);
        xb = ext(b, w, sb);
        p  = xa * xb;
        if (!f[2]) r = (f == 3'd0) ? p : (w ? p >>> 32 : p >>> 64);
        else if (xb == 0) r = f[1] ? xa : '1;
        else r = f[1] ? xa % xb : xa / xb;
        return w ? {{32{r[31]}}, r[31:0]} : r[63:0];
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
        int wd;
        logic sg;
        logic signed [127:0] xa, xb;
        wd = w ? 32 : 64;
        sg = f inside {3'd4, 3'd6};
        xa = ext(a, w, sg);
        xb = ext(b, w, sg);
        if (!f[2]) return wd / 2 + 3;
        if (xb == 0 || (sg && xb == -1 && xa == -(128'sd1 <<< (wd - 1)))) return 2;
        return wd + 3;
    endfunction

    // Reference tracker: judges outputs each cycle, then applies the events the next edge will see.
    logic        have_op = 1'b0;
    logic [63:0] exp_res = '0;
    int          exp_lat = 0;
    int          t_acc = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_resp_valid", 64'(o_resp_valid), 64'(0));
            chk("rst_busy", 64'(o_busy), 64'(0));
            chk("rst_result", o_result, 64'(0));
            have_op = 1'b0;
        end else begin
            chk("busy", 64'(o_busy), 64'(have_op));
            chk("req_ready", 64'(o_req_ready), 64'(!have_op));
            chk("resp_valid", 64'(o_resp_valid), 64'(have_op && (cyc - t_acc + 1 >= exp_lat)));
            if (have_op && o_resp_valid) chk("result", o_result, exp_res);
            if (i_flush) have_op = 1'b0;
            else if (have_op && o_resp_valid && i_resp_ready) have_op = 1'b0;
            else if (!have_op && i_req_valid) begin
                have_op = 1'b1;
                exp_res = model_res(i_funct3, i_w64, i_src_a, i_src_b);
                exp_lat = model_lat(i_funct3, i_w64, i_src_a, i_src_b);
                t_acc   = cyc + 1;
            end
        end
    end

    task automatic wait_resp();
        int n = 0;
        while (!o_resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("resp_timeout", 64'(o_resp_valid), 64'(1));
    endtask

    task automatic drive(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
        i_funct3 = f;
        i_w64    = w;
        i_src_a  = a;
        i_src_b  = b;
    endtask

    task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] lit, input int lit_lat);
        chk("model_res", model_res(f, w, a, b), lit);
        chk("model_lat", 64'(model_lat(f, w, a, b)), 64'(lit_lat));
        drive(f, w, a, b);
        i_req_valid = 1'b1;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        wait_resp();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_rst_req_ready", 64'(o_req_ready), 64'(1));
        chk("post_rst_busy", 64'(o_busy), 64'(0));
        @(posedge clk); #1;
        issue(3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 35);
        issue(3'd4, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 67);
        issue(3'd6, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 67);
        issue(3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'h2, 35);
        issue(3'd5, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        issue(3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234, 2);
        issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2);
        issue(3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 2);
        issue(3'd0, 1'b1, 64'h0000_0001_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 19);
        issue(3'd4, 1'b1, 64'd100, 64'd7, 64'd14, 35);
        issue(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 35);
        issue(3'd2, 1'b0, -64'sd2, '1, 64'hFFFF_FFFF_FFFF_FFFE, 35);
        issue(3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 35);
        issue(3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 35);
        issue(3'd6, 1'b0, 64'd7, -64'sd3, 64'd1, 67);
        issue(3'd5, 1'b0, '1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 67);
        issue(3'd6, 1'b1, 64'h0000_0000_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 2);
        // Response held for 5 cycles while a second request waits; it must only start after handoff.
        chk("model_divu", model_res(3'd5, 1'b0, 64'd1000, 64'd10), 64'd100);
        i_resp_ready = 1'b0;
        drive(3'd0, 1'b0, 64'd3, 64'd5);
        i_req_valid = 1'b1;
        @(posedge clk); #1;
        drive(3'd5, 1'b0, 64'd1000, 64'd10);
        wait_resp();
        repeat (5) @(posedge clk);
        #1 i_resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 i_req_valid = 1'b0;
        wait_resp();
        @(posedge clk); #1;
        // Flush while iterating.
        drive(3'd4, 1'b0, 64'd1000, 64'd7);
        i_req_valid = 1'b1;
        @(posedge clk); #1 i_req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 i_flush = 1'b1;
        @(posedge clk); #1 i_flush = 1'b0;
        chk("flush_iter_busy", 64'(o_busy), 64'(0));
        repeat (80) @(posedge clk);
        // Flush in the same cycle as a response handshake: response is dropped.
        #1 i_resp_ready = 1'b0;
        drive(3'd5, 1'b0, 64'd9, 64'd0);
        i_req_valid = 1'b1;
        @(posedge clk); #1 i_req_valid = 1'b0;
        wait_resp();
        @(posedge clk); #1;
        i_resp_ready = 1'b1;
        i_flush = 1'b1;
        @(posedge clk); #1 i_flush = 1'b0;
        chk("flush_done_valid", 64'(o_resp_valid), 64'(0));
        // Flush wins over a request in IDLE.
        drive(3'd0, 1'b0, 64'd2, 64'd2);
        i_req_valid = 1'b1;
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_flush = 1'b0;
        chk("flush_idle_busy", 64'(o_busy), 64'(0));
        @(posedge clk); #1;
        // Asynchronous reset mid-iteration.
        drive(3'd4, 1'b0, 64'd1000, 64'd7);
        i_req_valid = 1'b1;
        @(posedge clk); #1 i_req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(o_busy), 64'(0));
        chk("async_rst_valid", 64'(o_resp_valid), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(3'd4, 1'b1, 64'd100, 64'd7, 64'd14, 35);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
